// File: rtl/peer_status_rx.sv
// Receive side of the two-board status link: deserialises 3-bit status frames,
// checks parity and stop bit, confirms a code over two frames and tracks peer liveness.
module peer_status_rx #(
  parameter int CLK_PER_BIT    = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       global_clk,
  input  logic       rst,
  input  logic       link_rx,
  output logic [2:0] stat_sync,
  output logic       stat_valid,
  output logic       peer_alive,
  output logic       err_parity,
  output logic       err_frame
);

  localparam int TW = $clog2(CLK_PER_BIT);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

  state_t          state_q;
  logic            rx_meta_q, rx_s_q, rx_prev_q;
  logic [TW-1:0]   timer_q;
  logic [1:0]      bit_cnt_q;
  logic [2:0]      sh_q;
  logic            par_q, stop_q, done_q;
  logic [2:0]      cand_q;
  logic            cand_vld_q;
  logic [CW-1:0]   to_cnt_q;
  logic [2:0]      stat_sync_q;
  logic            stat_valid_q, peer_alive_q, err_parity_q, err_frame_q;

  logic frame_eval, frame_good, frame_bad, timeout_hit, bit_end, half_end;

  // The frame is judged one cycle after the stop sample, while the FSM still sits in STOP.
  assign frame_eval  = (state_q == STOP) && done_q;
  assign frame_good  = frame_eval && stop_q && ((^sh_q) == par_q);
  assign frame_bad   = frame_eval && !frame_good;
  assign timeout_hit = (to_cnt_q == TO_LAST);
  assign bit_end     = (timer_q == BIT_LAST);
  assign half_end    = (timer_q == HALF_LAST);

  always_ff @(posedge global_clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= link_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_ff @(posedge global_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      par_q        <= 1'b0;
      stop_q       <= 1'b0;
      done_q       <= 1'b0;
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      err_parity_q <= 1'b0;
      err_frame_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          done_q  <= 1'b0;
          if (rx_prev_q && !rx_s_q) begin
            bit_cnt_q <= '0;
            state_q   <= START;
          end
        end
        START: begin
          if (half_end) begin
            timer_q <= '0;
            state_q <= rx_s_q ? IDLE : DATA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            timer_q <= '0;
            sh_q    <= {rx_s_q, sh_q[2:1]};
            if (bit_cnt_q == 2'd2) state_q <= PARITY;
            else                   bit_cnt_q <= bit_cnt_q + 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            timer_q <= '0;
            par_q   <= rx_s_q;
            state_q <= STOP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        STOP: begin
          if (done_q) begin
            done_q <= 1'b0;
            if (!stop_q) begin
              err_frame_q <= 1'b1;
              state_q     <= BREAK;
            end else begin
              err_parity_q <= !frame_good;
              state_q      <= IDLE;
            end
          end else if (bit_end) begin
            timer_q <= '0;
            stop_q  <= rx_s_q;
            done_q  <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A good frame always beats a timeout landing in the same cycle.
  always_ff @(posedge global_clk or posedge rst) begin
    if (rst) begin
      cand_q       <= '0;
      cand_vld_q   <= 1'b0;
      to_cnt_q     <= '0;
      stat_sync_q  <= '0;
      stat_valid_q <= 1'b0;
      peer_alive_q <= 1'b0;
    end else begin
      stat_valid_q <= 1'b0;
      if (frame_good) begin
        to_cnt_q <= '0;
        if (cand_vld_q && (sh_q == cand_q)) begin
          stat_sync_q  <= sh_q;
          stat_valid_q <= 1'b1;
          peer_alive_q <= 1'b1;
        end else begin
          cand_q     <= sh_q;
          cand_vld_q <= 1'b1;
        end
      end else begin
        if (!timeout_hit) begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
          peer_alive_q <= 1'b0;
          stat_sync_q  <= '0;
          cand_vld_q   <= 1'b0;
        end
        if (frame_bad) cand_vld_q <= 1'b0;
      end
    end
  end

  assign stat_sync  = stat_sync_q;
  assign stat_valid = stat_valid_q;
  assign peer_alive = peer_alive_q;
  assign err_parity = err_parity_q;
  assign err_frame  = err_frame_q;

endmodule

// File: tb/tb_peer_status_rx.sv
// Directed bench for peer_status_rx: frames are driven bit by bit and results
// are compared against hand-computed codes and pulse counts.
module tb_peer_status_rx;

  localparam int CPB = 4;
  localparam int TO  = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       linkRx = 1'b1;
  logic [2:0] statSync;
  logic       statValid, peerAlive, errParity, errFrame;

  int checks = 0;
  int errors = 0;
  int validCnt = 0;
  int parCnt = 0;
  int frmCnt = 0;

  peer_status_rx #(.CLK_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
    .global_clk(clk),
    .rst(rst),
    .link_rx(linkRx),
    .stat_sync(statSync),
    .stat_valid(statValid),
    .peer_alive(peerAlive),
    .err_parity(errParity),
    .err_frame(errFrame)
  );

  always #5 clk = ~clk;

  // Every cycle a pulse output is high adds one, so a 1-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (statValid) validCnt++;
    if (errParity) parCnt++;
    if (errFrame)  frmCnt++;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one frame: start, d0..d2, parity, stop; caller must be at a negedge.
  task automatic applyStimulus(input logic [2:0] code, input logic par, input logic stop);
    logic [5:0] bits;
    bits = {stop, par, code[2], code[1], code[0], 1'b0};
    for (int i = 0; i < 6; i++) begin
      linkRx = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idleCycles(input int n);
    linkRx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    repeat (2) @(negedge clk);
    checkOutput("rst_stat", statSync, 0);
    checkOutput("rst_valid", statValid, 0);
    checkOutput("rst_alive", peerAlive, 0);
    checkOutput("rst_perr", errParity, 0);
    checkOutput("rst_ferr", errFrame, 0);
    rst = 1'b0;
    idleCycles(5);

    // Two identical good frames confirm the code.
    applyStimulus(3'b011, 1'b0, 1'b1); idleCycles(8);
    checkOutput("t1_stat_first", statSync, 0);
    checkOutput("t1_valid_first", validCnt, 0);
    checkOutput("t1_alive_first", peerAlive, 0);
    applyStimulus(3'b011, 1'b0, 1'b1); idleCycles(8);
    checkOutput("t1_stat", statSync, 3);
    checkOutput("t1_valid", validCnt, 1);
    checkOutput("t1_alive", peerAlive, 1);

    applyStimulus(3'b001, 1'b1, 1'b1); idleCycles(8);
    applyStimulus(3'b010, 1'b1, 1'b1); idleCycles(8);
    checkOutput("t2_stat_mid", statSync, 3);
    checkOutput("t2_valid_mid", validCnt, 1);
    applyStimulus(3'b010, 1'b1, 1'b1); idleCycles(8);
    checkOutput("t2_stat", statSync, 2);
    checkOutput("t2_valid", validCnt, 2);

    // Bad parity clears the candidate, so the following good frame cannot confirm.
    applyStimulus(3'b001, 1'b0, 1'b1); idleCycles(8);
    checkOutput("t3_perr", parCnt, 1);
    checkOutput("t3_ferr", frmCnt, 0);
    applyStimulus(3'b001, 1'b1, 1'b1); idleCycles(8);
    checkOutput("t3_stat", statSync, 2);
    checkOutput("t3_valid", validCnt, 2);
    checkOutput("t3_perr_after", parCnt, 1);

    applyStimulus(3'b111, 1'b1, 1'b0);
    linkRx = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t4_ferr", frmCnt, 1);
    checkOutput("t4_perr", parCnt, 1);
    checkOutput("t4_in_break", int'(dut.state_q), 5);
    idleCycles(12);
    checkOutput("t4_idle", int'(dut.state_q), 0);
    applyStimulus(3'b111, 1'b1, 1'b1); idleCycles(8);
    applyStimulus(3'b111, 1'b1, 1'b1); idleCycles(8);
    checkOutput("t4_stat", statSync, 7);
    checkOutput("t4_valid", validCnt, 3);
    checkOutput("t4_ferr_after", frmCnt, 1);

    linkRx = 1'b0;
    @(negedge clk);
    idleCycles(20);
    checkOutput("t5_stat", statSync, 7);
    checkOutput("t5_valid", validCnt, 3);
    checkOutput("t5_perr", parCnt, 1);
    checkOutput("t5_ferr", frmCnt, 1);
    checkOutput("t5_idle", int'(dut.state_q), 0);

    applyStimulus(3'b110, 1'b0, 1'b1); idleCycles(8);
    applyStimulus(3'b110, 1'b0, 1'b1); idleCycles(8);
    checkOutput("t6_stat", statSync, 6);
    checkOutput("t6_valid", validCnt, 4);
    idleCycles(100);
    checkOutput("t6_alive_before_to", peerAlive, 1);
    checkOutput("t6_stat_before_to", statSync, 6);
    idleCycles(150);
    checkOutput("t6_alive_after_to", peerAlive, 0);
    checkOutput("t6_stat_after_to", statSync, 0);

    applyStimulus(3'b101, 1'b0, 1'b1); idleCycles(8);
    applyStimulus(3'b101, 1'b0, 1'b1); idleCycles(8);
    checkOutput("t6_stat_reconf", statSync, 5);
    checkOutput("t6_alive_reconf", peerAlive, 1);
    checkOutput("t6_valid_reconf", validCnt, 5);

    linkRx = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_stat", statSync, 0);
    checkOutput("rst_mid_alive", peerAlive, 0);
    checkOutput("rst_mid_valid", statValid, 0);
    checkOutput("rst_mid_perr", errParity, 0);
    checkOutput("rst_mid_ferr", errFrame, 0);
    linkRx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idleCycles(20);
    checkOutput("post_rst_valid", validCnt, 5);
    checkOutput("post_rst_perr", parCnt, 1);
    checkOutput("post_rst_ferr", frmCnt, 1);
    applyStimulus(3'b011, 1'b0, 1'b1); idleCycles(8);
    applyStimulus(3'b011, 1'b0, 1'b1); idleCycles(8);
    checkOutput("post_rst_stat", statSync, 3);
    checkOutput("post_rst_alive", peerAlive, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
